fetch_queue: RTL

- Instruction fetch stage directly upstream of decode and its immediate mux.
- Generates sequential fetch addresses and issues them to instruction memory with a valid/ready request channel.
- Buffers in-order 64-bit responses in a small FIFO and presents {instruction, PC, fault} to decode with valid/ready.
- Handles pipeline redirects, including discarding responses still in flight.

---
 rtl/fetch_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential fetch requests under a credit limit and
// buffers in-order responses for decode; redirects flush and drop stale responses.
module fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [63:0] imem_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [63:0] imem_resp_data_in,
  input  logic        imem_resp_error_in,
  input  logic        redirect_valid_in,
  input  logic [63:0] redirect_pc_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [63:0] instr_out,
  output logic [63:0] instr_pc_out,
  output logic        instr_fault_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t        r_state;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  logic [63:0]   r_mem_data  [DEPTH];
  logic [63:0]   r_mem_pc    [DEPTH];
  logic          r_mem_fault [DEPTH];

  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_resp_push;
  logic          w_head_valid;
  logic          w_pop;
  logic [CW-1:0] w_outstanding_next;

  // Credit counts only registered occupancy and outstanding, so a pop frees a slot a cycle later.
  assign w_credit_used      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid        = reset_n_in & (r_state == ST_FETCH) & (w_credit_used < DEPTH_C)
                              & ~redirect_valid_in;
  assign w_req_fire         = w_req_valid & imem_req_ready_in;
  assign w_resp_push        = imem_resp_valid_in & ~redirect_valid_in & (r_drop == '0)
                              & (r_state == ST_FETCH);
  assign w_head_valid       = (r_count != '0);
  assign w_pop              = w_head_valid & instr_ready_in & ~redirect_valid_in;
  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid_in);

  assign imem_req_valid_out = w_req_valid;
  assign imem_addr_out      = r_fetch_pc;
  assign instr_valid_out    = w_head_valid;
  assign instr_out          = w_head_valid ? r_mem_data[r_rptr]  : 64'h0;
  assign instr_pc_out       = w_head_valid ? r_mem_pc[r_rptr]    : 64'h0;
  assign instr_fault_out    = w_head_valid ? r_mem_fault[r_rptr] : 1'b0;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect_valid_in) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_state    <= ST_FETCH;
        r_fetch_pc <= redirect_pc_in;
        r_resp_pc  <= redirect_pc_in;
        r_drop     <= w_outstanding_next;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (imem_resp_valid_in && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_resp_push) begin
          r_resp_pc <= r_resp_pc + PC_STEP;
          r_wptr    <= r_wptr + PW'(1);
          if (imem_resp_error_in) begin
            r_state <= ST_FAULT;
          end
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        r_count <= r_count + CW'(w_resp_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_resp_push) begin
      r_mem_data[r_wptr]  <= imem_resp_data_in;
      r_mem_pc[r_wptr]    <= r_resp_pc;
      r_mem_fault[r_wptr] <= imem_resp_error_in;
    end
  end

endmodule
